// File: rtl/mem_arb2.sv
// mem_arb2: two-master round-robin arbiter onto one single-port synchronous
// memory (1-cycle read latency); out-of-range accesses are absorbed.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   mX_addr/rd/wr     - byte address and read/write request, master X
//   mX_wrdata         - write data, master X
//   mX_waitreq        - high while master X's request is not accepted
//   mX_rddata/rdvalid - read return and its one-cycle strobe
//   mem_addr/wr/...   - word address, write strobe, data to/from memory
module mem_arb2 #(
    parameter int DW  = 16,
    parameter int MAW = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    m0_addr,
    input  logic           m0_rd,
    input  logic           m0_wr,
    input  logic [DW-1:0]  m0_wrdata,
    output logic           m0_waitreq,
    output logic [DW-1:0]  m0_rddata,
    output logic           m0_rdvalid,
    input  logic [15:0]    m1_addr,
    input  logic           m1_rd,
    input  logic           m1_wr,
    input  logic [DW-1:0]  m1_wrdata,
    output logic           m1_waitreq,
    output logic [DW-1:0]  m1_rddata,
    output logic           m1_rdvalid,
    output logic [MAW-1:0] mem_addr,
    output logic           mem_wr,
    output logic [DW-1:0]  mem_wrdata,
    input  logic [DW-1:0]  mem_rddata
);

    logic          req0, req1;
    logic          gnt0, gnt1, gnt_any;
    logic [15:0]   g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_rd, g_wr, g_in;

    // ptr_q = 1 favours m1 on a tie; reset value favours m0
    logic ptr_q, ptr_d;
    // read-return pipeline: valid, master id, in-range
    logic rv_q, rv_d;
    logic rid_q, rid_d;
    logic rin_q, rin_d;

    logic unused_addr;

    always_comb begin
        req0 = m0_rd | m0_wr;
        req1 = m1_rd | m1_wr;

        // reset gates grants so waitreq stays high while reset is low
        gnt0    = reset & req0 & (~req1 | ~ptr_q);
        gnt1    = reset & req1 & (~req0 | ptr_q);
        gnt_any = gnt0 | gnt1;

        // with no grant the address path defaults to m0
        g_addr  = gnt1 ? m1_addr   : m0_addr;
        g_wdata = gnt1 ? m1_wrdata : m0_wrdata;
        g_rd    = gnt1 ? m1_rd     : m0_rd;
        g_wr    = gnt1 ? m1_wr     : m0_wr;
        g_in    = (g_addr[15:12] == 4'h0);

        // favour whichever master was not just served
        ptr_d = gnt_any ? gnt0 : ptr_q;

        // rd+wr together is a write, so no read return
        rv_d  = gnt_any & g_rd & ~g_wr;
        rid_d = gnt1;
        rin_d = g_in;
    end

    assign unused_addr = ^g_addr;

    assign m0_waitreq = ~gnt0;
    assign m1_waitreq = ~gnt1;

    assign mem_addr   = g_addr[MAW:1];
    assign mem_wr     = gnt_any & g_wr & g_in;
    assign mem_wrdata = g_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
            rv_q  <= 1'b0;
            rid_q <= 1'b0;
            rin_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            rv_q  <= rv_d;
            rid_q <= rid_d;
            rin_q <= rin_d;
        end
    end

    assign m0_rdvalid = rv_q & ~rid_q;
    assign m1_rdvalid = rv_q & rid_q;

    // out-of-range reads return zero; idle master sees zero
    assign m0_rddata = (m0_rdvalid && rin_q) ? mem_rddata : '0;
    assign m1_rddata = (m1_rdvalid && rin_q) ? mem_rddata : '0;

endmodule

// File: tb/tb_mem_arb2.sv
// tb_mem_arb2: directed tests for mem_arb2 with a behavioural
// single-port synchronous memory attached.
module tb_mem_arb2;

    localparam int DW  = 16;
    localparam int MAW = 11;

    logic           clk;
    logic           reset;
    logic [15:0]    m0_addr, m1_addr;
    logic           m0_rd, m0_wr, m1_rd, m1_wr;
    logic [DW-1:0]  m0_wrdata, m1_wrdata;
    logic           m0_waitreq, m1_waitreq;
    logic [DW-1:0]  m0_rddata, m1_rddata;
    logic           m0_rdvalid, m1_rdvalid;
    logic [MAW-1:0] mem_addr;
    logic           mem_wr;
    logic [DW-1:0]  mem_wrdata;
    logic [DW-1:0]  mem_rddata;

    logic [DW-1:0] mem [0:(1<<MAW)-1];

    int checks = 0;
    int errors = 0;

    mem_arb2 #(.DW(DW), .MAW(MAW)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_wrdata(m0_wrdata), .m0_waitreq(m0_waitreq),
        .m0_rddata(m0_rddata), .m0_rdvalid(m0_rdvalid),
        .m1_addr(m1_addr), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_wrdata(m1_wrdata), .m1_waitreq(m1_waitreq),
        .m1_rddata(m1_rddata), .m1_rdvalid(m1_rdvalid),
        .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata)
    );

    always #5 clk = ~clk;

    // read-first synchronous memory, 1-cycle latency
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wrdata;
        mem_rddata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        m0_rd = 1; m0_wr = 1; m0_addr = 16'h0010; m0_wrdata = 16'h5555;
        m1_rd = 1; m1_addr = 16'h0010;
        tick; tick; #1;
        checks++; if (m0_waitreq !== 1'b1) begin errors++; $display("FAIL rst_m0_waitreq got %b want 1", m0_waitreq); end
        checks++; if (m1_waitreq !== 1'b1) begin errors++; $display("FAIL rst_m1_waitreq got %b want 1", m1_waitreq); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_wr got %b want 0", mem_wr); end
        checks++; if ({m0_rdvalid, m1_rdvalid} !== 2'b00) begin errors++; $display("FAIL rst_rdvalid got %b want 00", {m0_rdvalid, m1_rdvalid}); end
        checks++; if ({m0_rddata, m1_rddata} !== 32'h0) begin errors++; $display("FAIL rst_rddata got %h want 0", {m0_rddata, m1_rddata}); end
        idle;
        tick;
        reset = 1;
    endtask

    task automatic test_write_read;
        m0_wr = 1; m0_addr = 16'h0010; m0_wrdata = 16'hBEEF;
        #1;
        checks++; if (m0_waitreq !== 1'b0) begin errors++; $display("FAIL wr_waitreq got %b want 0", m0_waitreq); end
        checks++; if (mem_addr !== 11'h008) begin errors++; $display("FAIL wr_mem_addr got %h want 008", mem_addr); end
        checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL wr_mem_wr got %b want 1", mem_wr); end
        checks++; if (mem_wrdata !== 16'hBEEF) begin errors++; $display("FAIL wr_mem_wrdata got %h want beef", mem_wrdata); end
        tick;
        m0_wr = 0; m0_rd = 1;
        #1;
        checks++; if (m0_waitreq !== 1'b0) begin errors++; $display("FAIL rd_waitreq got %b want 0", m0_waitreq); end
        checks++; if (mem_addr !== 11'h008) begin errors++; $display("FAIL rd_mem_addr got %h want 008", mem_addr); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rd_mem_wr got %b want 0", mem_wr); end
        checks++; if (m0_rdvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rdvalid got %b want 0", m0_rdvalid); end
        tick;
        idle;
        #1;
        checks++; if (m0_rdvalid !== 1'b1) begin errors++; $display("FAIL rd_rdvalid got %b want 1", m0_rdvalid); end
        checks++; if (m0_rddata !== 16'hBEEF) begin errors++; $display("FAIL rd_rddata got %h want beef", m0_rddata); end
        checks++; if (m1_rdvalid !== 1'b0 || m1_rddata !== 16'h0) begin errors++; $display("FAIL rd_m1_quiet got %b/%h want 0/0000", m1_rdvalid, m1_rddata); end
        tick;
        #1;
        checks++; if (m0_rdvalid !== 1'b0) begin errors++; $display("FAIL rd_strobe_len got %b want 0", m0_rdvalid); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [4];
        vals[0] = 16'h1111; vals[1] = 16'h2222;
        vals[2] = 16'h3333; vals[3] = 16'h4444;
        for (int k = 0; k < 4; k++) begin
            m1_wr = 1; m1_addr = 16'(2 * k); m1_wrdata = vals[k];
            #1;
            checks++; if (m1_waitreq !== 1'b0 || mem_wr !== 1'b1) begin errors++; $display("FAIL b2b_wr%0d waitreq/mem_wr got %b/%b want 0/1", k, m1_waitreq, mem_wr); end
            tick;
        end
        m1_wr = 0;
        for (int k = 0; k < 4; k++) begin
            m1_rd = 1; m1_addr = 16'(2 * k);
            #1;
            checks++; if (m1_waitreq !== 1'b0) begin errors++; $display("FAIL b2b_rd%0d_waitreq got %b want 0", k, m1_waitreq); end
            if (k > 0) begin
                checks++; if (m1_rdvalid !== 1'b1 || m1_rddata !== vals[k-1]) begin errors++; $display("FAIL b2b_ret%0d got %b/%h want 1/%h", k - 1, m1_rdvalid, m1_rddata, vals[k-1]); end
            end else begin
                checks++; if (m1_rdvalid !== 1'b0) begin errors++; $display("FAIL b2b_first_rdvalid got %b want 0", m1_rdvalid); end
            end
            tick;
        end
        idle;
        #1;
        checks++; if (m1_rdvalid !== 1'b1 || m1_rddata !== vals[3]) begin errors++; $display("FAIL b2b_ret3 got %b/%h want 1/%h", m1_rdvalid, m1_rddata, vals[3]); end
        checks++; if (m0_rdvalid !== 1'b0) begin errors++; $display("FAIL b2b_m0_quiet got %b want 0", m0_rdvalid); end
        tick;
        #1;
        checks++; if (m1_rdvalid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", m1_rdvalid); end
    endtask

    task automatic test_round_robin;
        logic        g, p;
        logic [15:0] pdat;
        reset = 0;
        tick;
        reset = 1;
        m0_rd = 1; m0_addr = 16'h0000;
        m1_rd = 1; m1_addr = 16'h0004;
        for (int i = 0; i < 6; i++) begin
            g = (i % 2) == 1;
            #1;
            checks++; if ({m0_waitreq, m1_waitreq} !== {g, ~g}) begin errors++; $display("FAIL rr%0d_grant waitreq got %b%b want %b%b", i, m0_waitreq, m1_waitreq, g, ~g); end
            checks++; if (mem_addr !== (g ? 11'h002 : 11'h000)) begin errors++; $display("FAIL rr%0d_mem_addr got %h want %h", i, mem_addr, g ? 11'h002 : 11'h000); end
            if (i > 0) begin
                p = ~g;
                pdat = p ? 16'h3333 : 16'h1111;
                checks++; if ({m0_rdvalid, m1_rdvalid} !== {~p, p}) begin errors++; $display("FAIL rr%0d_rdvalid got %b%b want %b%b", i, m0_rdvalid, m1_rdvalid, ~p, p); end
                checks++; if ((p ? m1_rddata : m0_rddata) !== pdat) begin errors++; $display("FAIL rr%0d_rddata got %h want %h", i, p ? m1_rddata : m0_rddata, pdat); end
            end
            tick;
        end
        idle;
        #1;
        checks++; if ({m0_rdvalid, m1_rdvalid} !== 2'b01 || m1_rddata !== 16'h3333) begin errors++; $display("FAIL rr_last got %b%b/%h want 01/3333", m0_rdvalid, m1_rdvalid, m1_rddata); end
        tick;
    endtask

    task automatic test_out_of_range;
        m0_wr = 1; m0_addr = 16'h2000; m0_wrdata = 16'h1234;
        #1;
        checks++; if (m0_waitreq !== 1'b0) begin errors++; $display("FAIL oor_wr_waitreq got %b want 0", m0_waitreq); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL oor_mem_wr got %b want 0", mem_wr); end
        tick;
        m0_wr = 0; m0_rd = 1; m0_addr = 16'h3000;
        #1;
        checks++; if (m0_waitreq !== 1'b0) begin errors++; $display("FAIL oor_rd_waitreq got %b want 0", m0_waitreq); end
        tick;
        m0_addr = 16'h0000;
        #1;
        checks++; if (m0_rdvalid !== 1'b1 || m0_rddata !== 16'h0000) begin errors++; $display("FAIL oor_rd_data got %b/%h want 1/0000", m0_rdvalid, m0_rddata); end
        tick;
        idle;
        #1;
        checks++; if (m0_rdvalid !== 1'b1 || m0_rddata !== 16'h1111) begin errors++; $display("FAIL oor_no_clobber got %b/%h want 1/1111", m0_rdvalid, m0_rddata); end
        tick;
    endtask

    task automatic test_rd_wr_both;
        m0_rd = 1; m0_wr = 1; m0_addr = 16'h0020; m0_wrdata = 16'h00AA;
        #1;
        checks++; if (m0_waitreq !== 1'b0 || mem_wr !== 1'b1) begin errors++; $display("FAIL rw_accept got %b/%b want 0/1", m0_waitreq, mem_wr); end
        checks++; if (mem_addr !== 11'h010 || mem_wrdata !== 16'h00AA) begin errors++; $display("FAIL rw_mem got %h/%h want 010/00aa", mem_addr, mem_wrdata); end
        tick;
        m0_wr = 0;
        #1;
        checks++; if (m0_rdvalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdvalid got %b want 0", m0_rdvalid); end
        tick;
        idle;
        #1;
        checks++; if (m0_rdvalid !== 1'b1 || m0_rddata !== 16'h00AA) begin errors++; $display("FAIL rw_readback got %b/%h want 1/00aa", m0_rdvalid, m0_rddata); end
        tick;
    endtask

    task automatic test_reset_inflight;
        m0_rd = 1; m0_addr = 16'h0010;
        #1;
        checks++; if (m0_waitreq !== 1'b0) begin errors++; $display("FAIL rif_accept got %b want 0", m0_waitreq); end
        tick;
        reset = 0;
        m1_rd = 1; m1_addr = 16'h0010;
        #1;
        checks++; if ({m0_waitreq, m1_waitreq} !== 2'b11) begin errors++; $display("FAIL rif_waitreq got %b%b want 11", m0_waitreq, m1_waitreq); end
        checks++; if ({m0_rdvalid, m1_rdvalid} !== 2'b00) begin errors++; $display("FAIL rif_rdvalid got %b%b want 00", m0_rdvalid, m1_rdvalid); end
        tick;
        reset = 1;
        #1;
        checks++; if ({m0_waitreq, m1_waitreq} !== 2'b01) begin errors++; $display("FAIL rif_first_grant got %b%b want 01", m0_waitreq, m1_waitreq); end
        checks++; if ({m0_rdvalid, m1_rdvalid} !== 2'b00) begin errors++; $display("FAIL rif_stale got %b%b want 00", m0_rdvalid, m1_rdvalid); end
        tick;
        #1;
        checks++; if ({m0_waitreq, m1_waitreq} !== 2'b10) begin errors++; $display("FAIL rif_second_grant got %b%b want 10", m0_waitreq, m1_waitreq); end
        checks++; if (m0_rdvalid !== 1'b1 || m0_rddata !== 16'hBEEF) begin errors++; $display("FAIL rif_m0_ret got %b/%h want 1/beef", m0_rdvalid, m0_rddata); end
        tick;
        idle;
        #1;
        checks++; if (m1_rdvalid !== 1'b1 || m1_rddata !== 16'hBEEF) begin errors++; $display("FAIL rif_m1_ret got %b/%h want 1/beef", m1_rdvalid, m1_rddata); end
        tick;
    endtask

    initial begin
        clk = 0;
        reset = 0;
        m0_addr = 0; m1_addr = 0;
        m0_wrdata = 0; m1_wrdata = 0;
        idle;
        test_reset;
        test_write_read;
        test_back_to_back;
        test_round_robin;
        test_out_of_range;
        test_rd_wr_both;
        test_reset_inflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 SHALL have parameter DW, default 16, data width of master ports and memory.
REQ-002 SHALL have parameter MAW, default 11, memory word-address width (mem4k depth 2^MAW words).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m0_addr/m1_addr  in  16  byte address from master 0/1.
REQ-006 SHALL have ports m0_rd/m1_rd, m0_wr/m1_wr  in  1  read/write request, held until accepted.
REQ-007 SHALL have ports m0_wrdata/m1_wrdata  in  DW  write data.
REQ-008 SHALL have ports m0_waitreq/m1_waitreq  out  1  high = request not accepted this cycle.
REQ-009 SHALL have ports m0_rddata/m1_rddata  out  DW, m0_rdvalid/m1_rdvalid  out  1  read return and its strobe.
REQ-010 SHALL have ports mem_addr  out  MAW, mem_wr  out  1, mem_wrdata  out  DW, mem_rddata  in  DW  to single-port synchronous memory (1-cycle read latency).

Function
REQ-011 SHALL treat a master as requesting when rd or wr is high; rd and wr both high SHALL be executed as a write only, with no rdvalid.
REQ-012 SHALL accept at most one request per cycle; accepted master sees waitreq=0 combinationally in that cycle, other requester sees waitreq=1.
REQ-013 SHALL grant the sole requester every cycle with no idle bubbles, including back-to-back reads.
REQ-014 SHALL arbitrate round-robin when both request: priority pointer favours the master not granted most recently; pointer updates only on an accepted request.
REQ-015 SHALL drive mem_addr = granted_addr[MAW:1] (word address); with no grant, mem_addr from m0_addr and mem_wr=0.
REQ-016 SHALL treat addresses 0x0000-0x0FFF as in-range; out-of-range requests SHALL be accepted, writes dropped (mem_wr=0), reads returned as 0.
REQ-017 SHALL assert mem_wr only in the accepting cycle of an in-range write, with mem_wrdata = granted wrdata.
REQ-018 SHALL register {valid, master id, in-range} for each accepted read; in the next cycle assert exactly that master's rdvalid for one cycle with rddata = mem_rddata (in-range) or 0 (out-of-range).
REQ-019 SHALL hold non-selected rddata at 0 and rdvalid at 0.
REQ-020 SHALL return read data in acceptance order; read in cycle N returns in N+1 even if a write is accepted in N+1.
REQ-021 SHALL keep waitreq=1 for a master requesting neither rd nor wr only as a don't-care; waitreq SHALL be 1 for any non-granted requester.

Reset
REQ-022 SHALL, while reset=0, force m0_waitreq=m1_waitreq=1, rdvalid=0, rddata=0, mem_wr=0, pointer favouring m0.
REQ-023 SHALL discard any in-flight read on reset assertion; no rdvalid after release for pre-reset reads.
REQ-024 SHALL accept requests in the first rising edge after reset release.

Verification
REQ-025 SHALL cover: m0 writes 0xBEEF to 0x0010, then reads 0x0010 -> mem_addr=0x008 both cycles, m0_rdvalid=1 one cycle after read accept with m0_rddata=0xBEEF.
REQ-026 SHALL cover: m0 and m1 both read continuously after reset -> grants alternate m0,m1,m0,m1; each rdvalid follows its grant by one cycle with correct data.
REQ-027 SHALL cover: m1 alone issues 4 consecutive reads of 0x0000,0x0002,0x0004,0x0006 -> m1_waitreq=0 all 4 cycles, rdvalid 4 consecutive cycles, data in order.
REQ-028 SHALL cover: m0 writes 0x1234 to 0x2000 and reads 0x3000 -> mem_wr stays 0, read accepted, m0_rddata=0x0000 with rdvalid.
REQ-029 SHALL cover: m0 drives rd=wr=1 at 0x0020 with 0x00AA -> memory written 0x00AA, no m0_rdvalid.
REQ-030 SHALL cover: reset pulled low the cycle after a read is accepted -> rdvalid stays 0, waitreq=1 immediately; after release m0 is granted first on simultaneous requests.
